// File: rtl/alu_scheduler_if.sv
// Operation request and result handshake bundle between the two requesters,
// the shared-ALU scheduler and the result consumer.
interface alu_scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [2:0]            req0_oc;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [2:0]            req1_oc;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_id;
  logic                  res_err;

  modport slave (
    input  req0_valid, req0_oc, req0_a, req0_b,
    input  req1_valid, req1_oc, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, res_err
  );

  modport master (
    output req0_valid, req0_oc, req0_a, req0_b,
    output req1_valid, req1_oc, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, res_err
  );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters;
// each accepted operation is executed once and returned with its requester ID.
module alu #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [2:0]            oc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] f
);
  // Opcode decode; divide by zero yields zero here and is flagged upstream
  always_comb begin
    f = '0;
    case (oc)
      3'b000: f = a + b;
      3'b001: f = a - b;
      3'b010: f = a * b;
      3'b011: begin
        if (b == '0) begin
          f = '0;
        end else begin
          f = a / b;
        end
      end
      3'b100: f = ~a;
      3'b101: f = a ^ b;
      3'b110: f = a | b;
      3'b111: f = a & b;
      default: f = '0;
    endcase
  end
endmodule

module alu_scheduler #(
  parameter int DATA_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_scheduler_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic                  last_grant_r;
  logic                  grant0_s;
  logic                  grant1_s;
  logic                  accept_s;
  logic [2:0]            oc_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic                  id_r;
  logic [DATA_WIDTH-1:0] alu_f_s;
  logic                  res_valid_r;
  logic [DATA_WIDTH-1:0] res_data_r;
  logic                  res_id_r;
  logic                  res_err_r;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .oc (oc_r),
    .a  (a_r),
    .b  (b_r),
    .f  (alu_f_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Arbitration and next state; rst_n gating keeps both readies low in reset
  always_comb begin
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        grant0_s = rst_n & bus.req0_valid & (~bus.req1_valid | last_grant_r);
        grant1_s = rst_n & bus.req1_valid & (~bus.req0_valid | ~last_grant_r);
        if (grant0_s || grant1_s) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = DONE;
      DONE: begin
        if (bus.res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  assign accept_s       = grant0_s | grant1_s;
  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;

  // Capture the winning request; inputs are ignored after this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_r         <= 3'b000;
      a_r          <= '0;
      b_r          <= '0;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (accept_s) begin
      oc_r         <= grant1_s ? bus.req1_oc : bus.req0_oc;
      a_r          <= grant1_s ? bus.req1_a  : bus.req0_a;
      b_r          <= grant1_s ? bus.req1_b  : bus.req0_b;
      id_r         <= grant1_s;
      last_grant_r <= grant1_s;
    end
  end

  // Result register: loaded in EXEC, held through DONE, released on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_data_r  <= '0;
      res_id_r    <= 1'b0;
      res_err_r   <= 1'b0;
    end else if (state_r == EXEC) begin
      res_valid_r <= 1'b1;
      res_id_r    <= id_r;
      if (oc_r == 3'b011 && b_r == '0) begin
        res_data_r <= '1;
        res_err_r  <= 1'b1;
      end else begin
        res_data_r <= alu_f_s;
        res_err_r  <= 1'b0;
      end
    end else if (state_r == DONE && bus.res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_id    = res_id_r;
  assign bus.res_err   = res_err_r;
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: arbitration order, latency, divide by zero,
// backpressure, operand capture and mid-operation reset.
module tb_alu_scheduler;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_scheduler_if #(.DATA_WIDTH(16)) bus ();

  alu_scheduler #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic which, input logic v, input logic [2:0] oc,
                       input logic [15:0] a, input logic [15:0] b);
    if (which) begin
      bus.req1_valid = v; bus.req1_oc = oc; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_oc = oc; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic expect_res(input string tag, input logic [15:0] d, input logic id, input logic err);
    check_eq({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
    check_eq({tag, ".data"},  32'(bus.res_data),  32'(d));
    check_eq({tag, ".id"},    32'(bus.res_id),    32'(id));
    check_eq({tag, ".err"},   32'(bus.res_err),   32'(err));
  endtask

  // Starts at an IDLE negedge with res_ready=1, ends at the next IDLE negedge.
  task automatic do_op(input string tag, input logic which, input logic [2:0] oc,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d, input logic err);
    drive(which, 1'b1, oc, a, b);
    #1;
    check_eq({tag, ".rdy0"}, 32'(bus.req0_ready), 32'(!which));
    check_eq({tag, ".rdy1"}, 32'(bus.req1_ready), 32'(which));
    @(posedge clk); #1;
    drive(which, 1'b0, 3'b000, 16'h0000, 16'h0000);
    @(negedge clk);
    check_eq({tag, ".exec_valid"}, 32'(bus.res_valid), 32'd0);
    @(negedge clk);
    expect_res(tag, d, which, err);
    @(negedge clk);
    check_eq({tag, ".after_hs"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_d;
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 3'b000, 16'h0000, 16'h0000);
    bus.res_ready = 1'b1;

    // Reset state, readies held low even with both requesters valid
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_eq("rst.rdy0",  32'(bus.req0_ready), 32'd0);
    check_eq("rst.rdy1",  32'(bus.req1_ready), 32'd0);
    check_eq("rst.valid", 32'(bus.res_valid),  32'd0);
    check_eq("rst.data",  32'(bus.res_data),   32'd0);
    check_eq("rst.id",    32'(bus.res_id),     32'd0);
    check_eq("rst.err",   32'(bus.res_err),    32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("add",      1'b0, 3'b000, 16'h0003, 16'h0004, 16'h0007, 1'b0);
    do_op("div0",     1'b1, 3'b011, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
    do_op("div",      1'b1, 3'b011, 16'h0064, 16'h0007, 16'h000E, 1'b0);
    do_op("addwrap",  1'b1, 3'b000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    do_op("not",      1'b1, 3'b100, 16'h00FF, 16'h1234, 16'hFF00, 1'b0);
    do_op("or",       1'b1, 3'b110, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0);
    do_op("and",      1'b1, 3'b111, 16'hFF0F, 16'h0FF0, 16'h0F00, 1'b0);

    // Both continuously valid: grants alternate 0,1,0,1 starting with req0
    drive(1'b0, 1'b1, 3'b001, 16'h0010, 16'h0001);
    drive(1'b1, 1'b1, 3'b010, 16'h0100, 16'h0100);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq($sformatf("rr%0d.rdy0", k), 32'(bus.req0_ready), 32'(k % 2 == 0));
      check_eq($sformatf("rr%0d.rdy1", k), 32'(bus.req1_ready), 32'(k % 2 == 1));
      @(negedge clk);
      check_eq($sformatf("rr%0d.exec_rdy", k), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      check_eq($sformatf("rr%0d.exec_valid", k), 32'(bus.res_valid), 32'd0);
      @(negedge clk);
      exp_d = (k % 2 == 0) ? 16'h000F : 16'h0000;
      expect_res($sformatf("rr%0d", k), exp_d, 1'(k % 2), 1'b0);
      check_eq($sformatf("rr%0d.done_rdy", k), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure with req0 held valid throughout
    bus.res_ready = 1'b0;
    drive(1'b0, 1'b1, 3'b000, 16'h0001, 16'h0001);
    #1;
    check_eq("bp.rdy0", 32'(bus.req0_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    expect_res("bp.first", 16'h0002, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      expect_res($sformatf("bp.hold%0d", i), 16'h0002, 1'b0, 1'b0);
      check_eq($sformatf("bp.hold%0d.rdy0", i), 32'(bus.req0_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    #1;
    check_eq("bp.hs_rdy0", 32'(bus.req0_ready), 32'd0);
    @(negedge clk);
    #1;
    check_eq("bp.idle_valid", 32'(bus.res_valid),  32'd0);
    check_eq("bp.reaccept",   32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_res("bp.second", 16'h0002, 1'b0, 1'b0);
    @(negedge clk);

    // Operands changed right after accept must not affect the result
    drive(1'b0, 1'b1, 3'b101, 16'h00FF, 16'h0F0F);
    #1;
    check_eq("cap.rdy0", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'b111, 16'hAAAA, 16'h5555);
    @(negedge clk);
    @(negedge clk);
    expect_res("cap", 16'h0FF0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset while in DONE; rearbitration must favour req0 again
    drive(1'b0, 1'b1, 3'b010, 16'h0003, 16'h0005);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_res("mul", 16'h000F, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("mrst.valid", 32'(bus.res_valid), 32'd0);
    check_eq("mrst.data",  32'(bus.res_data),  32'd0);
    drive(1'b0, 1'b1, 3'b000, 16'h0005, 16'h0006);
    drive(1'b1, 1'b1, 3'b001, 16'h0009, 16'h0001);
    #1;
    check_eq("mrst.rdy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mrst.rdy0", 32'(bus.req0_ready), 32'd1);
    check_eq("mrst.rdy1", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_res("mrst.res", 16'h000B, 1'b0, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
